// File: rtl/spi_flash_reader.sv
// spi_flash_reader: one-byte cached SPI flash reader (READ 0x03) for a CPU memory bus.
// A sequential miss keeps chip select low and streams the next byte without a new command.
module spi_flash_reader #(
    parameter int CLK_DIV = 2,
    parameter int CS_GAP  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] address,
    input  logic        enable,
    output logic [7:0]  data_out,
    output logic        busy,
    output logic        spi_cs,
    output logic        spi_clk,
    output logic        spi_do,
    input  logic        spi_di
);
    typedef enum logic [2:0] {IDLE, GAP, CMD, DATA, DONE} state_t;
    state_t      state;
    logic [23:0] cached_addr, target;
    logic [7:0]  cached_data, sr, div;
    logic [31:0] cmd_sr;
    logic [4:0]  bits;
    logic        valid, ph, hit, div_end, last;
    assign hit      = valid && address == cached_addr;
    assign busy     = enable && (state != IDLE || !hit);
    assign data_out = cached_data;
    assign div_end  = div == 8'(CLK_DIV - 1);
    assign last     = bits == (state == CMD ? 5'd31 : 5'd7);
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            valid       <= 1'b0;
            cached_addr <= '0;
            cached_data <= '0;
            target      <= '0;
            sr          <= '0;
            cmd_sr      <= '0;
            div         <= '0;
            bits        <= '0;
            ph          <= 1'b0;
            spi_cs      <= 1'b1;
            spi_clk     <= 1'b0;
            spi_do      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (enable && !hit) begin
                    target <= address;
                    div    <= '0;
                    ph     <= 1'b0;
                    bits   <= '0;
                    if (!spi_cs && address == cached_addr + 24'd1) begin
                        state <= DATA;
                    end else if (!spi_cs) begin
                        state  <= GAP;
                        spi_cs <= 1'b1;
                    end else begin
                        state  <= CMD;
                        spi_cs <= 1'b0;
                        cmd_sr <= {8'h03, address};
                        spi_do <= 1'b0;
                    end
                end
                GAP: if (div == 8'(CS_GAP - 1)) begin
                    state  <= CMD;
                    div    <= '0;
                    spi_cs <= 1'b0;
                    cmd_sr <= {8'h03, target};
                    spi_do <= 1'b0;
                end else begin
                    div <= div + 8'd1;
                end
                CMD, DATA: if (!div_end) begin
                    div <= div + 8'd1;
                end else begin
                    div     <= '0;
                    ph      <= !ph;
                    spi_clk <= !ph;
                    // MISO is taken on the edge that raises spi_clk; MOSI moves as it falls
                    if (!ph) begin
                        if (state == DATA) sr <= {sr[6:0], spi_di};
                    end else begin
                        cmd_sr <= cmd_sr << 1;
                        spi_do <= cmd_sr[30];
                        bits   <= last ? 5'd0 : bits + 5'd1;
                        if (last) state <= (state == CMD) ? DATA : DONE;
                    end
                end
                DONE: begin
                    cached_data <= sr;
                    cached_addr <= target;
                    valid       <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_flash_reader.sv
// tb_spi_flash_reader: directed bench with a behavioural SPI flash answering READ (0x03).
module tb_spi_flash_reader;
    logic        clk = 1'b0, reset = 1'b1, enable = 1'b0, spi_di = 1'b0;
    logic [23:0] address = '0;
    logic [7:0]  data_out;
    logic        busy, spi_cs, spi_clk, spi_do;
    int          n_chk = 0, n_err = 0;
    int          fbits = 0, n_cmd = 0, n_pulse = 0, n_cshigh = 0;
    logic [31:0] fcmd = '0;
    logic [23:0] faddr = '0;

    spi_flash_reader #(.CLK_DIV(2), .CS_GAP(4)) dut (
        .clk(clk), .reset(reset), .address(address), .enable(enable),
        .data_out(data_out), .busy(busy), .spi_cs(spi_cs), .spi_clk(spi_clk),
        .spi_do(spi_do), .spi_di(spi_di)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] flash_byte(input logic [23:0] a);
        if (a == 24'h010000) return 8'hA5;
        if (a == 24'h010001) return 8'h3C;
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
    endfunction

    // Flash: 32 command bits in on rising spi_clk, then data out on falling spi_clk, auto-incrementing
    always @(posedge spi_clk or posedge spi_cs) begin
        if (spi_cs) begin
            fbits = 0;
        end else begin
            if (fbits < 32) fcmd = {fcmd[30:0], spi_do};
            fbits = fbits + 1;
            if (fbits == 32) begin
                faddr = fcmd[23:0];
                n_cmd = n_cmd + 1;
            end
        end
    end

    always @(negedge spi_clk) begin
        logic [7:0] fb;
        if (!spi_cs && fbits >= 32) begin
            fb     = flash_byte(faddr + 24'((fbits - 32) / 8));
            spi_di = fb[7 - ((fbits - 32) % 8)];
        end
    end

    always @(posedge spi_clk) n_pulse = n_pulse + 1;
    always @(posedge clk) if (spi_cs) n_cshigh = n_cshigh + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present a request at a negedge (cycle N) and count cycles until busy falls
    task automatic run(input logic [23:0] a, output int lat, output int dp, output int dc, output int dg);
        int p0, c0, g0;
        @(negedge clk);
        p0 = n_pulse; c0 = n_cmd; g0 = n_cshigh;
        address = a;
        enable  = 1'b1;
        #1;
        lat = 0;
        while (busy && lat < 2000) begin
            @(negedge clk);
            #1;
            lat++;
        end
        dp = n_pulse - p0; dc = n_cmd - c0; dg = n_cshigh - g0;
    endtask

    initial begin
        int lat, dp, dc, dg, p0, k;
        logic [7:0] d166;
        logic early;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_cs", spi_cs, 1);
        check("rst_clk", spi_clk, 0);
        check("rst_do", spi_do, 0);
        check("rst_data", data_out, 0);
        check("rst_busy", busy, 0);

        run(24'h010000, lat, dp, dc, dg);
        check("cold_lat", lat, 162);
        check("cold_data", data_out, 8'hA5);
        check("cold_cmd", fcmd, 32'h03010000);
        check("cold_pulses", dp, 40);

        run(24'h010001, lat, dp, dc, dg);
        check("strm_lat", lat, 34);
        check("strm_data", data_out, 8'h3C);
        check("strm_pulses", dp, 8);
        check("strm_newcmd", dc, 0);
        check("strm_cshigh", dg, 0);

        @(negedge clk);
        p0 = n_pulse;
        address = 24'h010001;
        enable  = 1'b1;
        #1;
        check("hit_busy", busy, 0);
        repeat (6) @(negedge clk);
        check("hit_pulses", n_pulse - p0, 0);
        check("hit_cs", spi_cs, 0);

        run(24'h000100, lat, dp, dc, dg);
        check("nseq_lat", lat, 166);
        check("nseq_cshigh", dg, 4);
        check("nseq_cmd", fcmd, 32'h03000100);
        check("nseq_data", data_out, 8'h5B);

        @(negedge clk);
        p0 = n_pulse;
        address = 24'h010000;
        k = 0;
        while (n_pulse - p0 < 10 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check("mid_reach", k < 1000, 1);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check("mid_cs", spi_cs, 1);
        check("mid_clk", spi_clk, 0);
        check("mid_data", data_out, 0);
        address = 24'h000000;
        #1;
        check("mid_invalid", busy, 1);
        reset  = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        run(24'h010000, lat, dp, dc, dg);
        check("recold_lat", lat, 162);
        check("recold_cmd", fcmd, 32'h03010000);
        check("recold_data", data_out, 8'hA5);

        run(24'hFFFFFF, lat, dp, dc, dg);
        check("top_lat", lat, 166);
        check("top_data", data_out, 8'hA5);
        run(24'h000000, lat, dp, dc, dg);
        check("wrap_lat", lat, 34);
        check("wrap_data", data_out, 8'h5A);
        check("wrap_newcmd", dc, 0);

        @(negedge clk);
        p0 = n_cmd;
        dg = n_cshigh;
        address = 24'h000200;
        enable  = 1'b1;
        early = 1'b0;
        d166  = '0;
        for (int i = 1; i < 332; i++) begin
            @(negedge clk);
            if (i == 20) address = 24'h000300;
            #1;
            if (i == 166) d166 = data_out;
            if (!busy) early = 1'b1;
        end
        @(negedge clk);
        #1;
        check("chg_held", early, 0);
        check("chg_first", d166, 8'h58);
        check("chg_busy", busy, 0);
        check("chg_data", data_out, 8'h59);
        check("chg_cmds", n_cmd - p0, 2);
        check("chg_cshigh", n_cshigh - dg, 8);
        check("chg_cmd", fcmd, 32'h03000300);
        enable = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
